// File: rtl/ch_avg_sched.sv
// ch_avg_sched: issues grouped RAM reads to the channel-averaging datapath and tracks its outputs to completion.
// Optional DRAIN watchdog is built when CH_AVG_SCHED_WATCHDOG_EN is defined.
module ch_avg_sched #(
    parameter int ADDR_WIDTH = 8,
    parameter int GRP_WIDTH  = 8,
    parameter int TMO_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [GRP_WIDTH-1:0]  num_groups,
    input  logic [1:0]            mode_cfg,
    input  logic                  ram_gnt,
    input  logic                  avg_out_vld,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  sp_in_vld,
    output logic [1:0]            parallel_mode,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int RW = GRP_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [RW-1:0]         rd_left, rd_left_nxt, ng_ext, rd_total;
    logic [GRP_WIDTH-1:0]  ng, ng_nxt, cnt, cnt_nxt, cnt_inc;
    logic [1:0]            pm_nxt;
    logic                  done_nxt, err_nxt, wd_exp;

    assign ng_ext    = RW'(num_groups);
    assign rd_total  = mode_cfg == 2'b01 ? ng_ext :
                       mode_cfg == 2'b10 ? ng_ext << 1 : (ng_ext << 1) + ng_ext;
    assign cnt_inc   = cnt + GRP_WIDTH'(avg_out_vld);
    assign busy      = state != IDLE;
    assign ram_rd_en = state == READ && ram_gnt;

`ifdef CH_AVG_SCHED_WATCHDOG_EN
    localparam int WW = $clog2(TMO_CYCLES + 1);
    logic [WW-1:0] wd;

    assign wd_exp = state == DRAIN && !avg_out_vld && wd == WW'(TMO_CYCLES - 1);

    // Count DRAIN cycles since entering DRAIN or since the last datapath output
    always_ff @(posedge clk or negedge rst)
        if (!rst) wd <= '0;
        else      wd <= (state != DRAIN || avg_out_vld) ? '0 : wd + WW'(1);
`else
    // Without the watchdog DRAIN never times out
    assign wd_exp = 1'b0 && TMO_CYCLES > 0;
`endif

    // Next-state and run bookkeeping; reads advance only on granted cycles
    always_comb begin
        state_nxt   = state;
        addr_nxt    = ram_addr;
        rd_left_nxt = rd_left;
        ng_nxt      = ng;
        cnt_nxt     = cnt;
        pm_nxt      = parallel_mode;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: if (start) begin
                if (mode_cfg == 2'b00) err_nxt = 1'b1;
                else begin
                    pm_nxt = mode_cfg;
                    if (num_groups == '0) done_nxt = 1'b1;
                    else begin
                        state_nxt   = READ;
                        addr_nxt    = base_addr;
                        rd_left_nxt = rd_total;
                        ng_nxt      = num_groups;
                        cnt_nxt     = '0;
                    end
                end
            end
            READ: begin
                cnt_nxt = cnt_inc;
                if (ram_gnt) begin
                    addr_nxt    = ram_addr + ADDR_WIDTH'(1);
                    rd_left_nxt = rd_left - RW'(1);
                    if (rd_left == RW'(1)) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                cnt_nxt = cnt_inc;
                if (cnt_inc == ng) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (wd_exp) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State registers; sp_in_vld mirrors the one-cycle RAM read latency
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state         <= IDLE;
            ram_addr      <= '0;
            rd_left       <= '0;
            ng            <= '0;
            cnt           <= '0;
            parallel_mode <= 2'b11;
            sp_in_vld     <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            state         <= state_nxt;
            ram_addr      <= addr_nxt;
            rd_left       <= rd_left_nxt;
            ng            <= ng_nxt;
            cnt           <= cnt_nxt;
            parallel_mode <= pm_nxt;
            sp_in_vld     <= ram_rd_en;
            done          <= done_nxt;
            err           <= err_nxt;
        end
endmodule

// File: tb/tb_ch_avg_sched.sv
// tb_ch_avg_sched: directed bench for ch_avg_sched (watchdog case built when CH_AVG_SCHED_WATCHDOG_EN is defined)
module tb_ch_avg_sched;
`ifdef CH_AVG_SCHED_WATCHDOG_EN
    localparam int TMO = 20;
`else
    localparam int TMO = 255;
`endif

    logic       clk = 0, rst = 0, start = 0, ram_gnt = 0, avg_out_vld = 0;
    logic [7:0] base_addr = 0, num_groups = 0;
    logic [1:0] mode_cfg = 0;
    logic       ram_rd_en, sp_in_vld, busy, done, err;
    logic [7:0] ram_addr;
    logic [1:0] parallel_mode;

    int         checks = 0, errors = 0;
    int         sp_bad = 0, gnt_bad = 0, both_bad = 0, done_n = 0, err_n = 0;
    logic [7:0] rd_log[$];
    logic       prev_rd;

    always #5 clk = ~clk;

    ch_avg_sched #(.ADDR_WIDTH(8), .GRP_WIDTH(8), .TMO_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_groups(num_groups), .mode_cfg(mode_cfg), .ram_gnt(ram_gnt),
        .avg_out_vld(avg_out_vld), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
        .sp_in_vld(sp_in_vld), .parallel_mode(parallel_mode), .busy(busy),
        .done(done), .err(err)
    );

    // Record every issued read and watch cycle-level rules at each clock edge
    always @(posedge clk or negedge rst)
        if (!rst) prev_rd <= 1'b0;
        else begin
            if (ram_rd_en) rd_log.push_back(ram_addr);
            if (sp_in_vld !== prev_rd) sp_bad++;
            if (ram_rd_en && !ram_gnt) gnt_bad++;
            if (done && err) both_bad++;
            if (done) done_n++;
            if (err) err_n++;
            prev_rd <= ram_rd_en;
        end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [7:0] b, input logic [7:0] n, input logic [1:0] m);
        base_addr  = b;
        num_groups = n;
        mode_cfg   = m;
        start      = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_reads(input string tag, input int target);
        int k = 0;
        while (rd_log.size() < target && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(tag, rd_log.size(), target);
    endtask

    task automatic chk_reads(input string tag, input int from, input logic [7:0] a0, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] e;
            e = a0 + 8'(i);
            chk(tag, (from + i < rd_log.size()) ? {24'd0, rd_log[from + i]} : 32'hdead, {24'd0, e});
        end
    endtask

    task automatic finish_run(input string tag, input int n);
        repeat (n - 1) begin
            avg_out_vld = 1;
            @(negedge clk);
            avg_out_vld = 0;
            @(negedge clk);
        end
        chk({tag, "_busy_pre"}, busy, 1);
        chk({tag, "_done_pre"}, done, 0);
        avg_out_vld = 1;
        @(negedge clk);
        avg_out_vld = 0;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_off"}, busy, 0);
        chk({tag, "_err"}, err, 0);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, done, 0);
    endtask

    initial begin
        int r0, d0, e0, k;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", ram_rd_en, 0);
        chk("rst_sp", sp_in_vld, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", ram_addr, 8'h00);
        chk("rst_pm", parallel_mode, 2'b11);
        rst = 1;
        @(negedge clk);

        // 4 groups of 3 with a permanent grant
        ram_gnt = 1;
        r0 = rd_log.size();
        go(8'h10, 4, 2'b11);
        chk("r1_busy", busy, 1);
        chk("r1_rd_first", ram_rd_en, 1);
        chk("r1_addr_first", ram_addr, 8'h10);
        chk("r1_pm", parallel_mode, 2'b11);
        wait_reads("r1_nreads", r0 + 12);
        chk("r1_rd_off", ram_rd_en, 0);
        chk("r1_sp_tail", sp_in_vld, 1);
        @(negedge clk);
        chk("r1_sp_done", sp_in_vld, 0);
`ifndef CH_AVG_SCHED_WATCHDOG_EN
        repeat (300) @(negedge clk);
        chk("r1_drain_wait", busy, 1);
`endif
        finish_run("r1", 4);
        chk_reads("r1_raddr", r0, 8'h10, 12);

        // Same run with the grant toggling every cycle
        r0 = rd_log.size();
        ram_gnt = 0;
        go(8'h10, 4, 2'b11);
        chk("r2_nogrant", ram_rd_en, 0);
        k = 0;
        while (rd_log.size() < r0 + 12 && k < 100) begin
            ram_gnt = ~ram_gnt;
            @(negedge clk);
            k++;
        end
        chk("r2_nreads", rd_log.size(), r0 + 12);
        chk("r2_rd_off", ram_rd_en, 0);
        ram_gnt = 1;
        finish_run("r2", 4);
        chk_reads("r2_raddr", r0, 8'h10, 12);
        chk("r2_gnt_rule", gnt_bad, 0);

        // Address wrap, groups of 2
        r0 = rd_log.size();
        go(8'hFE, 2, 2'b10);
        chk("r3_pm", parallel_mode, 2'b10);
        wait_reads("r3_nreads", r0 + 4);
        finish_run("r3", 2);
        chk_reads("r3_raddr", r0, 8'hFE, 4);

        // Illegal mode
        r0 = rd_log.size();
        go(8'h30, 3, 2'b00);
        chk("ill_err", err, 1);
        chk("ill_done", done, 0);
        chk("ill_busy", busy, 0);
        chk("ill_rd", ram_rd_en, 0);
        chk("ill_pm", parallel_mode, 2'b10);
        @(negedge clk);
        chk("ill_err_1cyc", err, 0);
        chk("ill_busy2", busy, 0);

        // Zero groups
        go(8'h30, 0, 2'b01);
        chk("zero_done", done, 1);
        chk("zero_err", err, 0);
        chk("zero_busy", busy, 0);
        @(negedge clk);
        chk("zero_done_1cyc", done, 0);
        chk("zero_noreads", rd_log.size(), r0);

        // Datapath output while idle is ignored
        avg_out_vld = 1;
        @(negedge clk);
        avg_out_vld = 0;
        @(negedge clk);
        chk("idle_vld_busy", busy, 0);
        chk("idle_vld_done", done, 0);

        // Restart while busy ignored, then reset during the 5th read
        r0 = rd_log.size();
        d0 = done_n;
        e0 = err_n;
        go(8'h40, 4, 2'b11);
        chk("r4_addr0", ram_addr, 8'h40);
        go(8'h80, 1, 2'b01);
        chk("r4_pm_hold", parallel_mode, 2'b11);
        chk("r4_addr1", ram_addr, 8'h41);
        repeat (3) @(negedge clk);
        chk("r4_addr4", ram_addr, 8'h44);
        chk("r4_rd5", ram_rd_en, 1);
        chk("r4_nreads", rd_log.size(), r0 + 4);
        #2 rst = 0;
        #1;
        chk("r4_rst_busy", busy, 0);
        chk("r4_rst_rd", ram_rd_en, 0);
        chk("r4_rst_sp", sp_in_vld, 0);
        chk("r4_rst_addr", ram_addr, 8'h00);
        chk("r4_rst_done", done, 0);
        chk("r4_rst_err", err, 0);
        chk("r4_rst_pm", parallel_mode, 2'b11);
        @(negedge clk);
        rst = 1;
        repeat (3) @(negedge clk);
        chk("r4_idle_busy", busy, 0);
        chk("r4_idle_rd", ram_rd_en, 0);
        chk("r4_no_done", done_n, d0);
        chk("r4_no_err", err_n, e0);
        chk("r4_no_reads", rd_log.size(), r0 + 4);

        // Single-sample run after reset
        r0 = rd_log.size();
        go(8'h20, 1, 2'b01);
        chk("r5_pm", parallel_mode, 2'b01);
        wait_reads("r5_nreads", r0 + 1);
        chk_reads("r5_raddr", r0, 8'h20, 1);
        finish_run("r5", 1);

`ifdef CH_AVG_SCHED_WATCHDOG_EN
        // Withhold datapath outputs in DRAIN until the watchdog fires
        r0 = rd_log.size();
        d0 = done_n;
        go(8'h50, 1, 2'b01);
        wait_reads("wd_nreads", r0 + 1);
        k = 0;
        while (!err && k < TMO + 20) begin
            @(negedge clk);
            k++;
        end
        chk("wd_cycles", k, TMO);
        chk("wd_busy", busy, 0);
        chk("wd_done", done, 0);
        @(negedge clk);
        chk("wd_err_1cyc", err, 0);
        chk("wd_no_done", done_n, d0);
`endif

        chk("sp_lag_rule", sp_bad, 0);
        chk("gnt_rule", gnt_bad, 0);
        chk("done_err_excl", both_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ch_avg_sched.md
CH_AVG_SCHED -- requirements
Module: ch_avg_sched

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 8, RAM address width; GRP_WIDTH, default 8, group-count width; TMO_CYCLES, default 255, watchdog limit.
REQ-002 clk  in  1  single system clock; all flops rising-edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle request to begin an averaging run.
REQ-005 base_addr  in  ADDR_WIDTH  first RAM address of the run, sampled on accepted start.
REQ-006 num_groups  in  GRP_WIDTH  number of averaged outputs to produce, sampled on accepted start.
REQ-007 mode_cfg  in  2  group size (01=1, 10=2, 11=3; 00 illegal), sampled on accepted start.
REQ-008 ram_gnt  in  1  RAM port grant from the shared-RAM arbiter; a read issues only when high.
REQ-009 avg_out_vld  in  1  out_vld from the channel-averaging datapath.
REQ-010 ram_rd_en  out  1  RAM read strobe.
REQ-011 ram_addr  out  ADDR_WIDTH  RAM read address.
REQ-012 sp_in_vld  out  1  sample-valid to the averaging datapath.
REQ-013 parallel_mode  out  2  group-size select to the averaging datapath.
REQ-014 busy  out  1  high from accepted start until done/err.
REQ-015 done  out  1  one-cycle pulse on run completion.
REQ-016 err  out  1  one-cycle pulse on illegal mode or watchdog expiry.

Function
REQ-017 FSM states SHALL be IDLE, READ, DRAIN; transitions: IDLE->READ on legal start with num_groups>0; READ->DRAIN after the last read issues; DRAIN->IDLE when the output count equals num_groups or on watchdog expiry.
REQ-018 Reads required SHALL be num_groups*G, G = group size from mode_cfg (at most 3*(2^GRP_WIDTH-1)).
REQ-019 In READ, ram_rd_en SHALL be high only in cycles where ram_gnt is high; ram_rd_en SHALL be low whenever ram_gnt is low.
REQ-020 ram_addr SHALL equal base_addr on the first read and increment by 1 after each issued read, wrapping modulo 2^ADDR_WIDTH.
REQ-021 sp_in_vld SHALL be ram_rd_en delayed by exactly one cycle (RAM read latency 1), including in the cycle after entering DRAIN.
REQ-022 parallel_mode SHALL load from mode_cfg on accepted start and hold constant until the next accepted start; reset value 2'b11.
REQ-023 The output counter SHALL increment on each avg_out_vld while busy; avg_out_vld while idle SHALL be ignored.
REQ-024 done SHALL pulse in the cycle after the counter reaches num_groups; busy SHALL fall in that same cycle.
REQ-025 start while busy SHALL be ignored with no effect on the run in progress.
REQ-026 start with num_groups=0 and legal mode SHALL produce done one cycle later, no reads, busy never asserted.
REQ-027 start with mode_cfg=00 SHALL produce err one cycle later, no reads, FSM stays IDLE, parallel_mode unchanged.
REQ-028 done and err SHALL never assert in the same cycle.

Reset
REQ-029 On rst low, all state SHALL clear asynchronously: FSM=IDLE, counters 0, ram_rd_en/sp_in_vld/busy/done/err=0, ram_addr=0, parallel_mode=2'b11.
REQ-030 Reset asserted mid-run SHALL abort the run with no done or err pulse; the first run after release requires a new start.

Configuration
REQ-031 Macro CH_AVG_SCHED_WATCHDOG_EN: when defined, a counter SHALL clear on each avg_out_vld and on entry to DRAIN, count DRAIN cycles, and after TMO_CYCLES cycles without avg_out_vld SHALL pulse err, return to IDLE, and drop busy.
REQ-032 When CH_AVG_SCHED_WATCHDOG_EN is undefined, no watchdog logic SHALL exist and DRAIN SHALL wait indefinitely for avg_out_vld.

Verification
REQ-033 base_addr=0x10, num_groups=4, mode=11, ram_gnt=1 -> 12 consecutive reads at 0x10..0x1B, sp_in_vld 12 cycles lagging by 1; 4 avg_out_vld -> done, busy low.
REQ-034 Same run with ram_gnt low on every other cycle -> 12 reads, addresses contiguous, no read while ram_gnt low, done after 4 outputs.
REQ-035 base_addr=0xFE, num_groups=2, mode=10 -> reads at 0xFE, 0xFF, 0x00, 0x01.
REQ-036 start with mode=00 -> err pulse, no ram_rd_en; start with num_groups=0 -> done next cycle, no ram_rd_en.
REQ-037 rst low during the 5th read of a 4x3 run -> all outputs 0 immediately, no done; second start mid-run ignored.
REQ-038 With CH_AVG_SCHED_WATCHDOG_EN, withhold avg_out_vld in DRAIN -> err exactly TMO_CYCLES cycles after the last clear event, busy low, done never asserted.
